// File: rtl/seat_pkg.sv
// ---------------------------------------------------------------------------
// seat_pkg
// Shared types for the seat manager slice: request opcodes, seat states,
// response codes, sweeper event kinds, the sweeper FSM states and a default
// width seat record for consumers such as the status display and logger.
// No ports (package).
// ---------------------------------------------------------------------------
package seat_pkg;

    localparam int STUDENT_W_DEF = 25;
    localparam int TIME_W_DEF    = 11;

    typedef enum logic [1:0] {
        OP_CHECKIN  = 2'd0,
        OP_CHECKOUT = 2'd1,
        OP_AWAY     = 2'd2,
        OP_RETURN   = 2'd3
    } op_e;

    // Encoding 3 is never produced by the design.
    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_OCCUPIED = 2'd1,
        ST_AWAY     = 2'd2
    } seat_state_e;

    typedef enum logic [1:0] {
        STS_OK         = 2'd0,
        STS_SEAT_TAKEN = 2'd1,
        STS_DENIED     = 2'd2,
        STS_DUPLICATE  = 2'd3
    } status_e;

    typedef enum logic {
        EVT_WARN    = 1'b0,
        EVT_RELEASE = 1'b1
    } evt_kind_e;

    typedef enum logic {
        SW_IDLE  = 1'b0,
        SW_SWEEP = 1'b1
    } sweep_state_e;

    typedef struct packed {
        seat_state_e                state;
        logic [STUDENT_W_DEF-1:0]   owner;
        logic [TIME_W_DEF-1:0]      remaining;
    } seat_rec_t;

endpackage

// File: rtl/seat_sweeper.sv
// ---------------------------------------------------------------------------
// seat_sweeper
// Time base for the seat manager. A divider counts clk cycles; every
// TICK_DIV cycles the global time counter advances and the FSM walks the
// seat indices 0..NUM_SEATS-1, one per cycle, so the top can age timers.
//
// Ports:
//   clk_i           system clock
//   rst_ni          asynchronous active-low reset
//   time_o          global tick counter, wraps at 2^TIME_W
//   sweep_active_o  high while a seat is being processed this cycle
//   sweep_idx_o     seat processed this cycle (valid with sweep_active_o)
// ---------------------------------------------------------------------------
module seat_sweeper
    import seat_pkg::*;
#(
    parameter int NUM_SEATS = 32,
    parameter int TIME_W    = 11,
    parameter int TICK_DIV  = 1000,
    parameter int SEAT_W    = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic [TIME_W-1:0] time_o,
    output logic              sweep_active_o,
    output logic [SEAT_W-1:0] sweep_idx_o
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [SEAT_W-1:0] IDX_LAST = SEAT_W'(NUM_SEATS - 1);

    logic [DIV_W-1:0]  div_q;
    logic [TIME_W-1:0] time_q;
    sweep_state_e      state_q;
    logic              active_q;
    logic [SEAT_W-1:0] idx_q;

    // Divider, time counter and IDLE/SWEEP walk. A wrap never lands inside
    // a sweep because TICK_DIV exceeds NUM_SEATS + 1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q    <= '0;
            time_q   <= '0;
            state_q  <= SW_IDLE;
            active_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            if (div_q == DIV_LAST) begin
                div_q  <= '0;
                time_q <= time_q + TIME_W'(1);
            end else begin
                div_q  <= div_q + DIV_W'(1);
            end

            case (state_q)
                SW_IDLE: begin
                    if (div_q == DIV_LAST) begin
                        state_q  <= SW_SWEEP;
                        active_q <= 1'b1;
                        idx_q    <= '0;
                    end
                end
                SW_SWEEP: begin
                    if (idx_q == IDX_LAST) begin
                        state_q  <= SW_IDLE;
                        active_q <= 1'b0;
                        idx_q    <= '0;
                    end else begin
                        idx_q    <= idx_q + SEAT_W'(1);
                    end
                end
                default: begin
                    state_q  <= SW_IDLE;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign time_o         = time_q;
    assign sweep_active_o = active_q;
    assign sweep_idx_o    = idx_q;

endmodule

// File: rtl/seat_manager.sv
// ---------------------------------------------------------------------------
// seat_manager
// Seat array with check-in / check-out / away / return request handling
// and a background sweeper that ages per-seat timers, moving expired
// sessions to AWAY (WARN event) and freeing expired away seats (RELEASE).
//
// Optional feature macro: SEAT_DUP_CHECK_EN
//   defined   - CHECKIN by a student already owning any seat -> DUPLICATE
//   undefined - no ownership search, DUPLICATE never returned
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   req_valid/req_ready               request handshake
//   req_op, req_student, req_seat     request fields
//   resp_valid, resp_status           one-cycle response, cycle after accept
//   cfg_session_limit, cfg_away_limit timer reload values in ticks
//   query_seat -> query_state/student/remaining  combinational seat read
//   time_out                          global tick counter
//   evt_valid, evt_kind, evt_seat     registered sweeper event pulse
// ---------------------------------------------------------------------------
module seat_manager
    import seat_pkg::*;
#(
    parameter int NUM_SEATS = 32,
    parameter int STUDENT_W = 25,
    parameter int TIME_W    = 11,
    parameter int TICK_DIV  = 1000,
    localparam int SEAT_W   = (NUM_SEATS > 1) ? $clog2(NUM_SEATS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [STUDENT_W-1:0] req_student,
    input  logic [SEAT_W-1:0]    req_seat,
    output logic                 resp_valid,
    output logic [1:0]           resp_status,
    input  logic [TIME_W-1:0]    cfg_session_limit,
    input  logic [TIME_W-1:0]    cfg_away_limit,
    input  logic [SEAT_W-1:0]    query_seat,
    output logic [1:0]           query_state,
    output logic [STUDENT_W-1:0] query_student,
    output logic [TIME_W-1:0]    query_remaining,
    output logic [TIME_W-1:0]    time_out,
    output logic                 evt_valid,
    output logic                 evt_kind,
    output logic [SEAT_W-1:0]    evt_seat
);

    if (TICK_DIV <= NUM_SEATS + 1) begin : g_bad_tick_div
        $error("seat_manager: TICK_DIV must be greater than NUM_SEATS + 1");
    end

    typedef struct packed {
        seat_state_e          state;
        logic [STUDENT_W-1:0] owner;
        logic [TIME_W-1:0]    remaining;
    } seat_t;

    seat_t             seat_q [NUM_SEATS];
    seat_t             seat_d [NUM_SEATS];

    logic              ready_en_q;
    logic              resp_valid_q;
    status_e           resp_status_q;
    logic              evt_valid_q, evt_valid_d;
    evt_kind_e         evt_kind_q, evt_kind_d;
    logic [SEAT_W-1:0] evt_seat_q, evt_seat_d;

    logic              sweep_active;
    logic [SEAT_W-1:0] sweep_idx;

    logic              req_fire;
    logic              req_in_range;
    logic [SEAT_W-1:0] req_idx;
    seat_t             cur_seat;
    logic              owner_match;
    status_e           status_d;
    op_e               op;
    logic              q_in_range;

    seat_sweeper #(
        .NUM_SEATS (NUM_SEATS),
        .TIME_W    (TIME_W),
        .TICK_DIV  (TICK_DIV),
        .SEAT_W    (SEAT_W)
    ) u_sweeper (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .time_o         (time_out),
        .sweep_active_o (sweep_active),
        .sweep_idx_o    (sweep_idx)
    );

    // The sweeper always wins a seat; a request to the seat being swept
    // simply waits one cycle, so both never write the same entry.
    assign req_ready    = ready_en_q && !(sweep_active && (sweep_idx == req_seat));
    assign req_fire     = req_valid && req_ready;
    assign req_in_range = ({1'b0, req_seat} < (SEAT_W + 1)'(NUM_SEATS));
    assign req_idx      = req_in_range ? req_seat : '0;
    assign cur_seat     = seat_q[req_idx];
    assign op           = op_e'(req_op);
    assign owner_match  = (cur_seat.state != ST_EMPTY) && (cur_seat.owner == req_student);

`ifdef SEAT_DUP_CHECK_EN
    logic dup_found;

    // Ownership search across every seat as it stands in the accept cycle.
    always_comb begin
        dup_found = 1'b0;
        for (int i = 0; i < NUM_SEATS; i++) begin
            if ((seat_q[i].state != ST_EMPTY) && (seat_q[i].owner == req_student)) begin
                dup_found = 1'b1;
            end
        end
    end
`endif

    // Request outcome, checked in priority order; anything other than OK
    // leaves the array untouched.
    always_comb begin
        status_d = STS_OK;
        if (!req_in_range) begin
            status_d = STS_DENIED;
        end else begin
            case (op)
                OP_CHECKIN: begin
                    if (cur_seat.state != ST_EMPTY) begin
                        status_d = STS_SEAT_TAKEN;
`ifdef SEAT_DUP_CHECK_EN
                    end else if (dup_found) begin
                        status_d = STS_DUPLICATE;
`endif
                    end
                end
                OP_CHECKOUT, OP_RETURN: begin
                    if (!owner_match) status_d = STS_DENIED;
                end
                OP_AWAY: begin
                    if (!owner_match || (cur_seat.state == ST_AWAY)) status_d = STS_DENIED;
                end
                default: status_d = STS_DENIED;
            endcase
        end
    end

    // Next array contents: sweeper ageing of one seat plus the accepted
    // request on a different seat.
    always_comb begin
        seat_d      = seat_q;
        evt_valid_d = 1'b0;
        evt_kind_d  = EVT_WARN;
        evt_seat_d  = '0;

        if (sweep_active && (seat_q[sweep_idx].state != ST_EMPTY)) begin
            if (seat_q[sweep_idx].remaining > TIME_W'(1)) begin
                seat_d[sweep_idx].remaining = seat_q[sweep_idx].remaining - TIME_W'(1);
            end else if (seat_q[sweep_idx].state == ST_OCCUPIED) begin
                seat_d[sweep_idx].state     = ST_AWAY;
                seat_d[sweep_idx].remaining = cfg_away_limit;
                evt_valid_d = 1'b1;
                evt_kind_d  = EVT_WARN;
                evt_seat_d  = sweep_idx;
            end else begin
                seat_d[sweep_idx].state     = ST_EMPTY;
                seat_d[sweep_idx].owner     = '0;
                seat_d[sweep_idx].remaining = '0;
                evt_valid_d = 1'b1;
                evt_kind_d  = EVT_RELEASE;
                evt_seat_d  = sweep_idx;
            end
        end

        if (req_fire && (status_d == STS_OK)) begin
            case (op)
                OP_CHECKIN: begin
                    seat_d[req_idx].state     = ST_OCCUPIED;
                    seat_d[req_idx].owner     = req_student;
                    seat_d[req_idx].remaining = cfg_session_limit;
                end
                OP_CHECKOUT: begin
                    seat_d[req_idx].state     = ST_EMPTY;
                    seat_d[req_idx].owner     = '0;
                    seat_d[req_idx].remaining = '0;
                end
                OP_AWAY: begin
                    seat_d[req_idx].state     = ST_AWAY;
                    seat_d[req_idx].remaining = cfg_away_limit;
                end
                OP_RETURN: begin
                    seat_d[req_idx].state     = ST_OCCUPIED;
                    seat_d[req_idx].remaining = cfg_session_limit;
                end
                default: ;
            endcase
        end
    end

    // State registers; ready_en_q holds req_ready low for the first cycle
    // after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SEATS; i++) begin
                seat_q[i] <= '0;
            end
            ready_en_q    <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_status_q <= STS_OK;
            evt_valid_q   <= 1'b0;
            evt_kind_q    <= EVT_WARN;
            evt_seat_q    <= '0;
        end else begin
            seat_q       <= seat_d;
            ready_en_q   <= 1'b1;
            resp_valid_q <= req_fire;
            if (req_fire) begin
                resp_status_q <= status_d;
            end
            evt_valid_q  <= evt_valid_d;
            evt_kind_q   <= evt_kind_d;
            evt_seat_q   <= evt_seat_d;
        end
    end

    assign q_in_range = ({1'b0, query_seat} < (SEAT_W + 1)'(NUM_SEATS));

    // Combinational query port; out-of-range indices read as an empty seat.
    always_comb begin
        query_state     = ST_EMPTY;
        query_student   = '0;
        query_remaining = '0;
        if (q_in_range) begin
            query_state     = seat_q[query_seat].state;
            query_student   = seat_q[query_seat].owner;
            query_remaining = seat_q[query_seat].remaining;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_status = resp_status_q;
    assign evt_valid   = evt_valid_q;
    assign evt_kind    = evt_kind_q;
    assign evt_seat    = evt_seat_q;

endmodule

// File: tb/tb_seat_manager.sv
// ---------------------------------------------------------------------------
// tb_seat_manager
// Self-checking bench for seat_manager with 4 seats, TICK_DIV 8, session 3,
// away 2. A behavioural seat model predicts responses, events, query values,
// req_ready and time_out every cycle; table vectors and hand sequences add
// fixed expectations for the documented scenarios.
// Honours SEAT_DUP_CHECK_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_seat_manager;
    import seat_pkg::*;

    localparam int NS   = 4;
    localparam int SW   = 2;
    localparam int STW  = 25;
    localparam int TW   = 11;
    localparam int TD   = 8;
    localparam int SESS = 3;
    localparam int AWL  = 2;

    logic           clk, rst_n;
    logic           req_valid, req_ready;
    logic [1:0]     req_op;
    logic [STW-1:0] req_student;
    logic [SW-1:0]  req_seat;
    logic           resp_valid;
    logic [1:0]     resp_status;
    logic [TW-1:0]  cfg_session_limit, cfg_away_limit;
    logic [SW-1:0]  query_seat;
    logic [1:0]     query_state;
    logic [STW-1:0] query_student;
    logic [TW-1:0]  query_remaining, time_out;
    logic           evt_valid, evt_kind;
    logic [SW-1:0]  evt_seat;

    seat_manager #(
        .NUM_SEATS (NS),
        .STUDENT_W (STW),
        .TIME_W    (TW),
        .TICK_DIV  (TD)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_op            (req_op),
        .req_student       (req_student),
        .req_seat          (req_seat),
        .resp_valid        (resp_valid),
        .resp_status       (resp_status),
        .cfg_session_limit (cfg_session_limit),
        .cfg_away_limit    (cfg_away_limit),
        .query_seat        (query_seat),
        .query_state       (query_state),
        .query_student     (query_student),
        .query_remaining   (query_remaining),
        .time_out          (time_out),
        .evt_valid         (evt_valid),
        .evt_kind          (evt_kind),
        .evt_seat          (evt_seat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int nChecks = 0;
    int nPass   = 0;

    // Model: per-seat state (0 empty, 1 occupied, 2 away), owner, ticks left.
    int mState [NS];
    int mOwner [NS];
    int mRem   [NS];
    int cyc;
    bit pRespV, pEvtV;
    int pRespS, pEvtK, pEvtS;
    bit lastAcc;
    int lastCyc;

    int obsReady, obsRespV, obsRespS, obsEvtV, obsEvtK, obsEvtS, obsTime;
    int obsQState, obsQRem;

    typedef struct {
        int op;
        int stu;
        int seat;
        int expStatus;
        int expState;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic modelReset();
        for (int i = 0; i < NS; i++) begin
            mState[i] = 0;
            mOwner[i] = 0;
            mRem[i]   = 0;
        end
        cyc    = 0;
        pRespV = 0;
        pEvtV  = 0;
    endtask

    function automatic int modelReq(input int op, input int stu, input int seat);
        if (seat >= NS) return 2;
        if (op == 0) begin
            if (mState[seat] != 0) return 1;
`ifdef SEAT_DUP_CHECK_EN
            for (int i = 0; i < NS; i++)
                if (mState[i] != 0 && mOwner[i] == stu) return 3;
`endif
            mState[seat] = 1;
            mOwner[seat] = stu;
            mRem[seat]   = SESS;
            return 0;
        end
        if (mState[seat] == 0 || mOwner[seat] != stu) return 2;
        if (op == 1) begin
            mState[seat] = 0;
            mOwner[seat] = 0;
            mRem[seat]   = 0;
        end else if (op == 2) begin
            if (mState[seat] == 2) return 2;
            mState[seat] = 2;
            mRem[seat]   = AWL;
        end else begin
            mState[seat] = 1;
            mRem[seat]   = SESS;
        end
        return 0;
    endfunction

    task automatic modelSweep(input int k);
        if (mState[k] == 0) return;
        if (mRem[k] > 1) begin
            mRem[k]--;
        end else if (mState[k] == 1) begin
            mState[k] = 2;
            mRem[k]   = AWL;
            pEvtV = 1; pEvtK = 0; pEvtS = k;
        end else begin
            mState[k] = 0;
            mOwner[k] = 0;
            mRem[k]   = 0;
            pEvtV = 1; pEvtK = 1; pEvtS = k;
        end
    endtask

    // One clock cycle: drive inputs, compare everything against the model,
    // then advance the model by what happens at the coming edge.
    task automatic runCycle(input bit v, input int op, input int stu, input int seat, input int qs);
        int sweepSeat;
        bit expReady;
        @(negedge clk);
        req_valid   = v;
        req_op      = 2'(op);
        req_student = STW'(stu);
        req_seat    = SW'(seat);
        query_seat  = SW'(qs);
        #1;
        obsReady  = int'(req_ready);
        obsRespV  = int'(resp_valid);
        obsRespS  = int'(resp_status);
        obsEvtV   = int'(evt_valid);
        obsEvtK   = int'(evt_kind);
        obsEvtS   = int'(evt_seat);
        obsTime   = int'(time_out);
        obsQState = int'(query_state);
        obsQRem   = int'(query_remaining);

        check("resp_valid", obsRespV, int'(pRespV));
        if (pRespV) check("resp_status", obsRespS, pRespS);
        check("evt_valid", obsEvtV, int'(pEvtV));
        if (pEvtV) begin
            check("evt_kind", obsEvtK, pEvtK);
            check("evt_seat", obsEvtS, pEvtS);
        end
        check("time_out", obsTime, (cyc / TD) % (1 << TW));

        sweepSeat = (cyc >= TD && (cyc % TD) < NS) ? (cyc % TD) : -1;
        expReady  = (cyc >= 1) && (sweepSeat != seat);
        check("req_ready", obsReady, int'(expReady));
        check("query_state", obsQState, mState[qs]);
        check("query_student", int'(query_student), mOwner[qs]);
        check("query_remaining", obsQRem, mRem[qs]);

        lastAcc = v && expReady;
        lastCyc = cyc;
        pRespV  = lastAcc;
        if (lastAcc) pRespS = modelReq(op, stu, seat);
        pEvtV = 0;
        if (sweepSeat >= 0) modelSweep(sweepSeat);
        cyc++;
    endtask

    // Hold a request until it is accepted (bounded).
    task automatic applyStimulus(input int op, input int stu, input int seat);
        bit done = 0;
        for (int k = 0; k < 4 && !done; k++) begin
            runCycle(1, op, stu, seat, seat);
            done = lastAcc;
        end
        if (!done) check("accept_timeout", 0, 1);
    endtask

    // Idle cycle following acceptance: response and resulting seat state.
    task automatic checkOutput(input string name, input int seat, input int expStatus, input int expState);
        runCycle(0, 0, 0, 0, seat);
        check({name, "_resp_valid"}, obsRespV, 1);
        check({name, "_status"}, obsRespS, expStatus);
        check({name, "_state"}, obsQState, expState);
    endtask

    initial begin
        int t0;
        bit found;

        rst_n = 1'b0;
        req_valid = 1'b0; req_op = '0; req_student = '0; req_seat = '0; query_seat = '0;
        cfg_session_limit = TW'(SESS);
        cfg_away_limit    = TW'(AWL);

        // Vector table: op, student, seat, expected status, expected state.
        vecs.push_back('{0, 123, 2, 0, 1});
        vecs.push_back('{0, 456, 2, 1, 1});
        vecs.push_back('{1, 456, 2, 2, 1});
        vecs.push_back('{0,  50, 0, 0, 1});
        vecs.push_back('{2,  50, 0, 0, 2});
        vecs.push_back('{2,  50, 0, 2, 2});
        vecs.push_back('{3,  50, 0, 0, 1});
        vecs.push_back('{0,  50, 0, 1, 1});
        vecs.push_back('{2,  51, 0, 2, 1});
        vecs.push_back('{1, 123, 2, 0, 0});
        vecs.push_back('{0,   9, 3, 0, 1});
`ifdef SEAT_DUP_CHECK_EN
        vecs.push_back('{0,   9, 2, 3, 0});
`else
        vecs.push_back('{0,   9, 2, 0, 1});
`endif
        vecs.push_back('{1,   9, 3, 0, 0});
        vecs.push_back('{3,   9, 3, 2, 0});

        // Reset state while reset is held.
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_resp_valid", int'(resp_valid), 0);
        check("rst_evt_valid", int'(evt_valid), 0);
        check("rst_time_out", int'(time_out), 0);
        for (int i = 0; i < NS; i++) begin
            query_seat = SW'(i);
            #1;
            check($sformatf("rst_state_%0d", i), int'(query_state), 0);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        modelReset();

        runCycle(0, 0, 0, 0, 0);
        check("first_cycle_ready", obsReady, 0);
        runCycle(0, 0, 0, 0, 0);
        check("second_cycle_ready", obsReady, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].stu, vecs[i].seat);
            checkOutput($sformatf("vec%0d", i), vecs[i].seat, vecs[i].expStatus, vecs[i].expState);
        end

        // Timer expiry on seat 1: check in outside a sweep window.
        for (int k = 0; k < 16 && (cyc % TD) != 4; k++) runCycle(0, 0, 0, 0, 1);
        applyStimulus(0, 7, 1);
        t0 = lastCyc / TD;
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            runCycle(0, 0, 0, 0, 1);
            found = (obsEvtV == 1) && (obsEvtS == 1);
        end
        check("warn_seen", int'(found), 1);
        if (found) begin
            check("warn_kind", obsEvtK, 0);
            check("warn_tick", obsTime, t0 + 3);
            check("warn_state", obsQState, 2);
            check("warn_remaining", obsQRem, AWL);
        end
        found = 0;
        for (int k = 0; k < 24 && !found; k++) begin
            runCycle(0, 0, 0, 0, 1);
            found = (obsEvtV == 1) && (obsEvtS == 1);
        end
        check("release_seen", int'(found), 1);
        if (found) begin
            check("release_kind", obsEvtK, 1);
            check("release_tick", obsTime, t0 + 5);
            check("release_state", obsQState, 0);
        end

        // Request collides with the sweep of seat 3.
        for (int k = 0; k < 16 && !(cyc >= TD && (cyc % TD) == 3); k++) runCycle(0, 0, 0, 0, 3);
        runCycle(1, 0, 77, 3, 3);
        check("stall_ready_low", obsReady, 0);
        runCycle(1, 0, 77, 3, 3);
        check("stall_ready_high", obsReady, 1);
        runCycle(0, 0, 0, 0, 3);
        check("stall_resp_valid", obsRespV, 1);
        check("stall_resp_status", obsRespS, 0);
        check("stall_state", obsQState, 1);

        // Randomized traffic against the model, with a reset in the middle.
        for (int k = 0; k < 400; k++) begin
            if (k == 200) begin
                @(negedge clk);
                #2 rst_n = 1'b0;
                #1;
                check("midrst_req_ready", int'(req_ready), 0);
                check("midrst_resp_valid", int'(resp_valid), 0);
                check("midrst_evt_valid", int'(evt_valid), 0);
                check("midrst_time_out", int'(time_out), 0);
                for (int i = 0; i < NS; i++) begin
                    query_seat = SW'(i);
                    #1;
                    check($sformatf("midrst_state_%0d", i), int'(query_state), 0);
                end
                repeat (2) @(posedge clk);
                #2 rst_n = 1'b1;
                modelReset();
            end
            runCycle(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                     int'($urandom_range(1, 4)), int'($urandom_range(0, NS - 1)),
                     int'($urandom_range(0, NS - 1)));
        end
        runCycle(0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
